bowling_lane: RTL
=================

Name: bowling_lane

Overview:
- Transmitter side of the bowling scoring interface.
- Accepts a stream of per-ball knock-down counts from a stimulus source through a valid/ready handshake.
- Enforces frame rules: strikes, spares, tenth-frame bonus balls, and pin-count legality.
- Drives the scorer's roll, pin_count and calculate_score inputs, then emits exactly one calculate_score pulse per frame and reports done.

Parameters:
- FRAMES, 10, frames per game; also the number of calculate_score pulses issued.
- MAX_PINS, 10, pins standing at the start of each frame or rack.

Ports:
- clock  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high; returns block to IDLE
- start  in  1  begin a new game; honoured only in IDLE or DONE
- in_valid  in  1  in_pins is valid this cycle
- in_pins  in  4  pins knocked down by this ball
- in_ready  out  1  lane can accept a ball
- score_reset  out  1  one-cycle pulse to clear the scorer at game start
- roll  out  1  one-cycle strobe; pin_count valid with it
- pin_count  out  4  legal pins for this ball
- calculate_score  out  1  scoring strobe
- frame  out  4  current frame, 0..FRAMES-1
- ball  out  2  ball index within the frame, 0..2
- rolls_sent  out  5  balls emitted this game, 0..21
- illegal  out  1  sticky; an in_pins value exceeded standing pins
- busy  out  1  high in PLAY and SCORE
- done  out  1  high in DONE

Behaviour:
- Reset: state IDLE; all outputs 0. standing=MAX_PINS; strike0 (frame-0 first-ball strike flag) cleared.
- A reset in any state, including mid-game or mid-SCORE, aborts immediately. No further roll or calculate_score pulses are issued.
- IDLE and DONE, on start:
  - Next cycle: score_reset=1 for one cycle.
  - Counters, frame, ball and illegal are cleared; standing=MAX_PINS.
  - State moves to PLAY.
- PLAY:
  - in_ready=1 (registered; high from the cycle after entry).
  - A ball is accepted when in_valid&&in_ready.
  - Legalised pin value p=min(in_pins,standing). If in_pins>standing, illegal is set and stays set until the next start.
  - roll=1 and pin_count=p appear exactly one cycle after acceptance. rolls_sent increments in the same cycle.
  - Back-to-back acceptance is allowed, so roll may be high on consecutive cycles.
- Frames 0..FRAMES-2:
  - ball0, p==standing (strike): frame+1, ball=0, standing=MAX_PINS.
  - ball0, otherwise: standing-=p, ball=1.
  - ball1: frame+1, ball=0, standing=MAX_PINS.
- Last frame (FRAMES-1):
  - ball0: record strike0=(p==MAX_PINS). If strike, standing=MAX_PINS; else standing-=p. Then ball=1.
  - ball1: if strike0 or standing-p==0, a bonus ball is granted: ball=2. Standing becomes MAX_PINS if standing-p==0, otherwise standing-p. If no bonus is granted, the game ends.
  - ball2: the game ends.
- Game end:
  - in_ready drops the cycle after the final acceptance. Any in_valid held afterwards is ignored.
  - SCORE starts the cycle after the final roll pulse, so roll and calculate_score are never high together.
- SCORE:
  - calculate_score=1 for exactly FRAMES consecutive cycles, then state moves to DONE.
  - start is ignored in PLAY and SCORE.
- DONE: done=1 and frame/ball/rolls_sent are held until start or reset.
- Widths: standing is 4 bits and p≤standing, so standing never underflows. rolls_sent saturates at 21, which the frame rules make unreachable.

Decomposition:
- Shared package bowling_pkg holds:
  - state enum {IDLE, PLAY, SCORE, DONE}
  - MAX_PINS, FRAMES, LAST_FRAME=FRAMES-1
  - widths: PIN_W=4, FRAME_W=4, ROLL_IDX_W=5
- One sub-module, bowling_frame_tracker, owns frame/ball/standing/strike0 and the legalisation logic.
  - Inputs: accept, in_pins.
  - Outputs: p, illegal_hit, game_end.
  - The top module holds the FSM, handshake, SCORE counter and output registers.

Test Plan:
- Gutter game, 20×in_pins=0 → 20 roll pulses, pin_count=0; in_ready low after the 20th; 10 calculate_score; done=1; scorer score=0.
- Perfect game, 12×10 → 12 roll pulses; frame=9, ball=2 on the last; no 13th accepted; scorer score=300.
- All spares, 21×5 → 21 rolls; bonus ball granted in frame 9; rolls_sent=21; scorer score=150.
- Open tenth, 18×1 then 3,4 → 20 rolls; third ball refused (in_ready=0); scorer score=25.
- Illegal input, frame 0: 7 then in_pins=6 → pin_count=3, illegal=1 and sticky, frame→1, standing=10.
- Reset after 5 balls → all outputs 0, IDLE; then start → score_reset pulse; a fresh gutter game completes with score=0.

Source files
------------

// File: rtl/bowling_pkg.sv
// Shared types and constants for the bowling lane transmitter.
package bowling_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        SCORE,
        DONE
    } state_t;

    localparam int FRAMES     = 10;
    localparam int MAX_PINS   = 10;
    localparam int LAST_FRAME = FRAMES - 1;
    localparam int MAX_ROLLS  = 21;

    localparam int PIN_W      = 4;
    localparam int FRAME_W    = 4;
    localparam int ROLL_IDX_W = 5;

endpackage

// File: rtl/bowling_lane_if.sv
// Ball stream from the stimulus source into the lane: valid/ready with a pin count.
interface bowling_lane_if;
    import bowling_pkg::*;

    logic             in_valid;
    logic [PIN_W-1:0] in_pins;
    logic             in_ready;

    modport master (
        output in_valid,
        output in_pins,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_pins,
        output in_ready
    );

endinterface

// File: rtl/bowling_frame_tracker.sv
// Tracks frame, ball and standing pins; legalises each ball and flags the game-ending ball.
module bowling_frame_tracker
    import bowling_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               accept,
    input  logic [PIN_W-1:0]   in_pins,
    output logic [PIN_W-1:0]   p,
    output logic               illegal_hit,
    output logic               game_end,
    output logic [FRAME_W-1:0] frame,
    output logic [1:0]         ball
);

    localparam logic [PIN_W-1:0] FULL_RACK = PIN_W'(MAX_PINS);

    logic [PIN_W-1:0] standing;
    logic [PIN_W-1:0] remain;
    logic [PIN_W-1:0] rack_next;
    logic             strike0;
    logic             last_frame;
    logic             bonus;

    always_comb begin
        illegal_hit = in_pins > standing;
        p           = illegal_hit ? standing : in_pins;
        remain      = standing - p;
        rack_next   = (remain == '0) ? FULL_RACK : remain;
        last_frame  = frame == FRAME_W'(LAST_FRAME);
        // Only meaningful on the second ball of the last frame.
        bonus       = strike0 || (remain == '0);
        game_end    = last_frame && (((ball == 2'd1) && !bonus) || (ball == 2'd2));
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            frame    <= '0;
            ball     <= '0;
            standing <= FULL_RACK;
            strike0  <= 1'b0;
        end else if (accept) begin
            if (!last_frame) begin
                if ((ball == 2'd0) && (remain != '0)) begin
                    standing <= remain;
                    ball     <= 2'd1;
                end else begin
                    frame    <= frame + FRAME_W'(1);
                    ball     <= 2'd0;
                    standing <= FULL_RACK;
                end
            end else begin
                case (ball)
                    2'd0: begin
                        strike0  <= (p == FULL_RACK);
                        standing <= rack_next;
                        ball     <= 2'd1;
                    end
                    2'd1: begin
                        if (bonus) begin
                            standing <= rack_next;
                            ball     <= 2'd2;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/bowling_lane.sv
// Bowling lane transmitter: accepts balls, drives the scorer's roll/pin_count and score strobes.
//   state | meaning
//   IDLE  | after reset, waiting for start
//   PLAY  | accepting balls; drains the final roll before scoring
//   SCORE | calculate_score held high for FRAMES cycles
//   DONE  | game complete, results held until start
module bowling_lane
    import bowling_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    bowling_lane_if.slave         ball_if,
    output logic                  score_reset,
    output logic                  roll,
    output logic [PIN_W-1:0]      pin_count,
    output logic                  calculate_score,
    output logic [FRAME_W-1:0]    frame,
    output logic [1:0]            ball,
    output logic [ROLL_IDX_W-1:0] rolls_sent,
    output logic                  illegal,
    output logic                  busy,
    output logic                  done
);

    state_t             state;
    logic               accept;
    logic               clear;
    logic               game_over;
    logic [FRAME_W-1:0] score_cnt;
    logic [PIN_W-1:0]   p;
    logic               illegal_hit;
    logic               game_end;

    assign accept = (state == PLAY) && ball_if.in_valid && ball_if.in_ready;
    assign clear  = ((state == IDLE) || (state == DONE)) && start;

    bowling_frame_tracker u_tracker (
        .clock       (clock),
        .reset       (reset),
        .clear       (clear),
        .accept      (accept),
        .in_pins     (ball_if.in_pins),
        .p           (p),
        .illegal_hit (illegal_hit),
        .game_end    (game_end),
        .frame       (frame),
        .ball        (ball)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            ball_if.in_ready <= 1'b0;
            score_reset      <= 1'b0;
            roll             <= 1'b0;
            pin_count        <= '0;
            calculate_score  <= 1'b0;
            rolls_sent       <= '0;
            illegal          <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            game_over        <= 1'b0;
            score_cnt        <= '0;
        end else begin
            score_reset <= 1'b0;
            roll        <= accept;
            pin_count   <= accept ? p : '0;

            if (accept) begin
                if (rolls_sent != ROLL_IDX_W'(MAX_ROLLS))
                    rolls_sent <= rolls_sent + ROLL_IDX_W'(1);
                if (illegal_hit)
                    illegal <= 1'b1;
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= PLAY;
                        score_reset <= 1'b1;
                        rolls_sent  <= '0;
                        illegal     <= 1'b0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        game_over   <= 1'b0;
                    end
                end
                PLAY: begin
                    // game_over delays SCORE by one cycle so the last roll never overlaps it.
                    if (game_over) begin
                        state            <= SCORE;
                        calculate_score  <= 1'b1;
                        score_cnt        <= FRAME_W'(FRAMES - 1);
                        ball_if.in_ready <= 1'b0;
                    end else if (accept && game_end) begin
                        ball_if.in_ready <= 1'b0;
                        game_over        <= 1'b1;
                    end else begin
                        ball_if.in_ready <= 1'b1;
                    end
                end
                SCORE: begin
                    if (score_cnt == '0) begin
                        calculate_score <= 1'b0;
                        state           <= DONE;
                        busy            <= 1'b0;
                        done            <= 1'b1;
                    end else begin
                        score_cnt <= score_cnt - FRAME_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
